// File: rtl/mac_acc_sgn.sv
// mac_acc_sgn: streaming signed multiply-accumulate stage.
// Operand pairs arrive over a valid/ready handshake and are registered in a
// one-deep operand stage. A combinational MulAddSgn then folds each pair into
// the accumulator. The finished sum is presented on a registered valid/ready
// result port and is held stable under backpressure.

package lau_pkg;
    // Implementation style for the multiply-add core.
    typedef enum logic {
        SLOW = 1'b0,
        FAST = 1'b1
    } speed_e;
endpackage : lau_pkg

// MulAddSgn: o_p = i_a + i_x * i_y, signed two's complement, modulo 2^widthA.
// FAST maps to a plain multiplier. SLOW builds the product as a shift-add sum.
// The two styles give the same result.
module MulAddSgn
    import lau_pkg::*;
#(
    parameter int     widthX = 8,
    parameter int     widthY = 8,
    parameter int     widthA = 20,
    parameter speed_e speed  = FAST
) (
    input  logic signed [widthX-1:0] i_x,
    input  logic signed [widthY-1:0] i_y,
    input  logic signed [widthA-1:0] i_a,
    output logic signed [widthA-1:0] o_p
);
    // Sign-extend both operands to the result width. A product modulo
    // 2^widthA then needs no wider intermediate.
    logic signed [widthA-1:0] w_x_ext;
    logic signed [widthA-1:0] w_y_ext;
    logic signed [widthA-1:0] w_prod;

    assign w_x_ext = widthA'(i_x);
    assign w_y_ext = widthA'(i_y);

    if (speed == FAST) begin : g_fast
        assign w_prod = w_x_ext * w_y_ext;
    end else begin : g_slow
        // Shift-add product over every bit of the sign-extended multiplicand
        always_comb begin
            // NOTE: assign a default first so that no path can leave w_prod
            // unassigned. An unassigned path would infer a latch.
            w_prod = '0;
            for (int i = 0; i < widthA; i++) begin
                if (w_y_ext[i]) begin
                    w_prod = w_prod + (w_x_ext << i);
                end
            end
        end
    end

    assign o_p = i_a + w_prod;
endmodule : MulAddSgn

module mac_acc_sgn
    import lau_pkg::*;
#(
    parameter int     widthX = 8,
    parameter int     widthY = 8,
    parameter int     widthA = 20,
    parameter int     widthN = 8,
    parameter speed_e speed  = FAST
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic signed [widthX-1:0] X_i,
    input  logic signed [widthY-1:0] Y_i,
    input  logic signed [widthA-1:0] bias_i,
    input  logic                     last_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [widthA-1:0] P_o,
    output logic        [widthN-1:0] cnt_o
);
    // Operand stage
    logic                     r_s_valid;
    logic signed [widthX-1:0] r_s_x;
    logic signed [widthY-1:0] r_s_y;
    logic                     r_s_last;
    logic                     r_s_first;
    logic signed [widthA-1:0] r_s_bias;

    // Vector tracking, accumulator and result
    logic                     r_first;
    logic signed [widthA-1:0] r_acc;
    logic        [widthN-1:0] r_cnt;
    logic                     r_out_valid;

    logic                     w_accept;
    logic signed [widthA-1:0] w_augend;
    logic signed [widthA-1:0] w_sum;

    // Input stalls while a result waits for its handshake, and also while the
    // last beat of a vector is still in the operand stage. The ready signal
    // depends only on registers.
    assign in_ready_o = ~r_out_valid & ~(r_s_valid & r_s_last);
    assign w_accept   = in_valid_i & in_ready_o;

    // The first beat of a vector restarts from its bias. Later beats use the
    // running sum.
    assign w_augend = r_s_first ? r_s_bias : r_acc;

    MulAddSgn #(
        .widthX (widthX),
        .widthY (widthY),
        .widthA (widthA),
        .speed  (speed)
    ) u_muladd (
        .i_x (r_s_x),
        .i_y (r_s_y),
        .i_a (w_augend),
        .o_p (w_sum)
    );

    // Operand stage capture and start-of-vector tracking. A flush drops any
    // beat accepted in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state uses non-blocking assignments only. All
            // flops then sample the pre-edge values, whatever the block order.
            r_s_valid <= 1'b0;
            // NOTE: the datapath registers are reset as well. The outputs then
            // read as a defined zero straight after reset.
            r_s_x     <= '0;
            r_s_y     <= '0;
            r_s_last  <= 1'b0;
            r_s_first <= 1'b0;
            r_s_bias  <= '0;
            r_first   <= 1'b1;
        end else if (flush_i) begin
            r_s_valid <= 1'b0;
            r_first   <= 1'b1;
        end else begin
            r_s_valid <= w_accept;
            if (w_accept) begin
                r_s_x     <= X_i;
                r_s_y     <= Y_i;
                r_s_last  <= last_i;
                r_s_first <= r_first;
                r_s_bias  <= bias_i;
                r_first   <= last_i;
            end
        end
    end

    // Fold the staged operand pair into the accumulator and the beat counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (!flush_i && r_s_valid) begin
            r_acc <= w_sum;
            r_cnt <= r_s_first ? widthN'(1) : r_cnt + widthN'(1);
        end
    end

    // Raise the result when the last beat folds in, and drop it on handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
        end else if (r_s_valid && r_s_last) begin
            r_out_valid <= 1'b1;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    // The accumulator cannot change while the result is pending, because the
    // input is stalled. The result therefore holds under backpressure.
    assign out_valid_o = r_out_valid;
    assign P_o         = r_acc;
    assign cnt_o       = r_cnt;
endmodule : mac_acc_sgn
